// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package irq_pkg;

    localparam int N_IRQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    // The id field must be exactly wide enough to index every line.
    function automatic bit prio_valid(input int n_irq, input int id_w);
        return (n_irq >= 2) && (n_irq <= 16) && (id_w == $clog2(n_irq));
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_IRQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        id  = '0;
        any = |req;
        // Scan from the top down so the lowest index is the last assignment.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = i[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: edge detect, pending/overrun latches, priority select, request FSM.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer on each irq_in line.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             ExtIAck,
    input  logic             ovr_clr,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] irq_pending,
    output logic [N_IRQ-1:0] irq_overrun
);

    generate
        if (!prio_valid(N_IRQ, ID_W)) begin : g_bad_param
            $error("irq_ctrl: ID_W must equal $clog2(N_IRQ) and N_IRQ must be 2..16");
        end
    endgenerate

    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] hist_reg;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] pending_reg;
    logic [N_IRQ-1:0] overrun_reg;
    logic [N_IRQ-1:0] sel_req;
    logic [ID_W-1:0]  win_id;
    logic             win_any;
    logic             ack_clr;

    irq_state_t       state_reg, state_next;
    logic [ID_W-1:0]  id_reg, id_next;
    logic             ext_irq_reg, ext_irq_next;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_reg;
    logic [N_IRQ-1:0] sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_s = sync2_reg;
`else
    assign irq_s = irq_in;
`endif

    // History resets to 0, so a line already high at reset release reads as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= irq_s;
        end
    end

    assign ack_clr = (state_reg == REQ) && ExtIAck;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            assign rise[gi]    = irq_s[gi] & ~hist_reg[gi];
            assign clr_vec[gi] = ack_clr && (id_reg == ID_W'(gi));

            // A fresh edge beats the ack-clear; only an edge on an uncleared pending line is an overrun.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pending_reg[gi] <= 1'b0;
                    overrun_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= (pending_reg[gi] & ~clr_vec[gi]) | rise[gi];
                    overrun_reg[gi] <= (overrun_reg[gi] & ~ovr_clr)
                                     | (rise[gi] & pending_reg[gi] & ~clr_vec[gi]);
                end
            end
        end
    endgenerate

    assign sel_req = pending_reg & irq_mask;

    irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req (sel_req),
        .id  (win_id),
        .any (win_any)
    );

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    id_next    = win_id;
                    state_next = REQ;
                end
            end
            // The request is never withdrawn; id stays frozen until ack.
            REQ: begin
                if (ExtIAck) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        ext_irq_next = (state_next == REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            ext_irq_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            ext_irq_reg <= ext_irq_next;
        end
    end

    assign ExtIRQ      = ext_irq_reg;
    assign irq_id      = id_reg;
    assign irq_pending = pending_reg;
    assign irq_overrun = overrun_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (default build, no input synchronizer).
module tb_irq_ctrl;

    localparam int N_IRQ = 4;
    localparam int ID_W  = 2;

    logic             clk;
    logic             reset;
    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] irq_mask;
    logic             ExtIAck;
    logic             ovr_clr;
    logic             ExtIRQ;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] irq_pending;
    logic [N_IRQ-1:0] irq_overrun;

    int tests_run;
    int tests_failed;

    irq_ctrl #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .ExtIAck     (ExtIAck),
        .ovr_clr     (ovr_clr),
        .ExtIRQ      (ExtIRQ),
        .irq_id      (irq_id),
        .irq_pending (irq_pending),
        .irq_overrun (irq_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_once();
        ExtIAck = 1'b1;
        tick();
        ExtIAck = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        irq_in   = '0;
        irq_mask = '0;
        ExtIAck  = 1'b0;
        ovr_clr  = 1'b0;
        tick(2);
        check("rst_extirq",  32'(ExtIRQ), 32'd0);
        check("rst_id",      32'(irq_id), 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        check("rst_overrun", 32'(irq_overrun), 32'd0);
        reset = 1'b0;
        tick();

        // Single edge on line 2
        irq_mask = 4'b1111;
        irq_in   = 4'b0100;
        tick();
        check("t1_pending", 32'(irq_pending), 32'h4);
        check("t1_extirq_lat", 32'(ExtIRQ), 32'd0);
        tick();
        check("t1_extirq", 32'(ExtIRQ), 32'd1);
        check("t1_id", 32'(irq_id), 32'd2);
        ack_once();
        check("t1_ack_pending", 32'(irq_pending), 32'h0);
        check("t1_ack_extirq", 32'(ExtIRQ), 32'd0);
        irq_in = 4'b0000;
        tick();
        check("t1_gap_extirq", 32'(ExtIRQ), 32'd0);
        tick();

        // Lines 1 and 3 together: 1 first, then 3
        irq_in = 4'b1010;
        tick();
        check("t2_pending", 32'(irq_pending), 32'hA);
        tick();
        check("t2_id_first", 32'(irq_id), 32'd1);
        ack_once();
        check("t2_pending_mid", 32'(irq_pending), 32'h8);
        tick();
        check("t2_gap_extirq", 32'(ExtIRQ), 32'd0);
        tick();
        check("t2_extirq_second", 32'(ExtIRQ), 32'd1);
        check("t2_id_second", 32'(irq_id), 32'd3);
        ack_once();
        check("t2_pending_end", 32'(irq_pending), 32'h0);
        irq_in = 4'b0000;
        tick(3);

        // Higher-priority edge during service does not pre-empt
        irq_in = 4'b0100;
        tick(2);
        check("t3_id_before", 32'(irq_id), 32'd2);
        irq_in = 4'b0101;
        tick();
        check("t3_pending_both", 32'(irq_pending), 32'h5);
        tick();
        check("t3_id_frozen", 32'(irq_id), 32'd2);
        check("t3_extirq_held", 32'(ExtIRQ), 32'd1);
        ack_once();
        check("t3_pending_after", 32'(irq_pending), 32'h1);
        tick(2);
        check("t3_extirq_next", 32'(ExtIRQ), 32'd1);
        check("t3_id_next", 32'(irq_id), 32'd0);
        ack_once();
        irq_in = 4'b0000;
        tick(3);

        // Masked line latches pending but does not request
        irq_mask = 4'b1110;
        irq_in   = 4'b0001;
        tick();
        check("t4_pending_masked", 32'(irq_pending), 32'h1);
        tick(2);
        check("t4_extirq_masked", 32'(ExtIRQ), 32'd0);
        irq_mask = 4'b1111;
        tick();
        check("t4_extirq_unmask", 32'(ExtIRQ), 32'd1);
        check("t4_id_unmask", 32'(irq_id), 32'd0);
        ack_once();
        irq_in = 4'b0000;
        tick(3);

        // Overrun on line 1, then clear, then edge coinciding with ack
        irq_in = 4'b0010;
        tick(2);
        check("t5_id", 32'(irq_id), 32'd1);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0010;
        tick();
        check("t5_overrun", 32'(irq_overrun), 32'h2);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t5_overrun_clr", 32'(irq_overrun), 32'h0);
        irq_in = 4'b0000;
        tick();
        irq_in  = 4'b0010;
        ack_once();
        check("t5_pending_kept", 32'(irq_pending), 32'h2);
        check("t5_overrun_none", 32'(irq_overrun), 32'h0);
        check("t5_extirq_gap", 32'(ExtIRQ), 32'd0);
        tick(2);
        check("t5_extirq_again", 32'(ExtIRQ), 32'd1);
        check("t5_id_again", 32'(irq_id), 32'd1);
        ack_once();
        check("t5_pending_end", 32'(irq_pending), 32'h0);
        irq_in = 4'b0000;
        tick(3);

        // Line held high across reset release, then reset mid-request
        irq_in = 4'b0001;
        reset  = 1'b1;
        tick(2);
        check("t6_rst_pending", 32'(irq_pending), 32'h0);
        reset = 1'b0;
        tick();
        check("t6_edge_after_rst", 32'(irq_pending), 32'h1);
        tick();
        check("t6_extirq", 32'(ExtIRQ), 32'd1);
        check("t6_id", 32'(irq_id), 32'd0);
        tick(2);
        check("t6_single_edge", 32'(irq_overrun), 32'h0);
        reset = 1'b1;
        #1;
        check("t6_async_extirq", 32'(ExtIRQ), 32'd0);
        check("t6_async_pending", 32'(irq_pending), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
